// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch FSM state type.
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        FS_RUN  = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer parking a fetched instruction while decode is stalled.
module fetch_hold_buf
    import rv32i_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        wr_i,
    input  logic        clr_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        full_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        full_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            full_q  <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0;
        end else if (clr_i) begin
            full_q  <= 1'b0;
        end else if (wr_i) begin
            full_q  <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Single-outstanding instruction fetch with stall skid buffer and flush redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_decode_o,
    output logic [31:0] pc_decode_o,
    output logic        valid_decode_o
);
    import rv32i_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  rsp_pc_q, rsp_pc_d;
    logic [31:0]  dec_instr_q, dec_instr_d;
    logic [31:0]  dec_pc_q, dec_pc_d;
    logic         dec_vld_q, dec_vld_d;

    logic         buf_full, buf_wr, buf_clr;
    logic [31:0]  buf_instr, buf_pc;
    logic         req, gnt, keep;

    // Gated by reset so the bus sees no request while rstn_i is low.
    assign req     = rstn_i && (state_q == FS_RUN) && !buf_full && !flush_i;
    assign gnt     = req && imem_gnt_i;
    assign keep    = imem_rvalid_i && (state_q == FS_WAIT) && !flush_i;
    assign buf_wr  = keep && stall_i;
    assign buf_clr = flush_i || (!stall_i && buf_full);

    fetch_hold_buf u_hold_buf (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .wr_i    (buf_wr),
        .clr_i   (buf_clr),
        .instr_i (imem_rdata_i),
        .pc_i    (rsp_pc_q),
        .full_o  (buf_full),
        .instr_o (buf_instr),
        .pc_o    (buf_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;
        dec_vld_d   = dec_vld_q;

        case (state_q)
            FS_RUN:  if (gnt) state_d = FS_WAIT;
            FS_WAIT: if (imem_rvalid_i) state_d = FS_RUN;
                     else if (flush_i) state_d = FS_DROP;
            FS_DROP: if (imem_rvalid_i) state_d = FS_RUN;
            default: state_d = FS_RUN;
        endcase

        if (flush_i)  pc_d = {redirect_pc_i[31:2], 2'b00};
        else if (gnt) pc_d = pc_q + 32'd4;
        if (gnt)      rsp_pc_d = pc_q;

        // Buffered instruction is older than any new response, so it drains first.
        if (flush_i) begin
            dec_instr_d = NOP_INSTR;
            dec_vld_d   = 1'b0;
        end else if (!stall_i) begin
            if (buf_full) begin
                dec_instr_d = buf_instr;
                dec_pc_d    = buf_pc;
                dec_vld_d   = 1'b1;
            end else if (keep) begin
                dec_instr_d = imem_rdata_i;
                dec_pc_d    = rsp_pc_q;
                dec_vld_d   = 1'b1;
            end else begin
                dec_instr_d = NOP_INSTR;
                dec_vld_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= FS_RUN;
            pc_q        <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            dec_instr_q <= NOP_INSTR;
            dec_pc_q    <= 32'h0;
            dec_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rsp_pc_q    <= rsp_pc_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
            dec_vld_q   <= dec_vld_d;
        end
    end

    assign imem_req_o     = req;
    assign imem_addr_o    = pc_q;
    assign instr_decode_o = dec_instr_q;
    assign pc_decode_o    = dec_pc_q;
    assign valid_decode_o = dec_vld_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: directed scenarios then random traffic against a queue-based reference.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        stall_i = 1'b0, flush_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] instr_decode_o, pc_decode_o;
    logic        valid_decode_o;

    always #5 clk_i = ~clk_i;

    fetch_stage dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .redirect_pc_i  (redirect_pc_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .instr_decode_o (instr_decode_o),
        .pc_decode_o    (pc_decode_o),
        .valid_decode_o (valid_decode_o)
    );

    typedef struct packed { logic [31:0] i; logic [31:0] p; } ent_t;

    int n_chk = 0, n_err = 0;

    // Reference: fetch PC, one in-flight request (with kill flag), a skid queue and the decode slot.
    logic [31:0] m_pc, m_opc, m_di, m_dpc;
    logic        m_dv, m_out, m_kill;
    int          rcnt;
    ent_t        bq[$];
    logic [31:0] glog[$], dlog[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_opc = 32'h0; m_di = NOP; m_dpc = 32'h0;
        m_dv = 1'b0; m_out = 1'b0; m_kill = 1'b0; rcnt = 0;
        bq.delete();
    endtask

    // One clock: drive at negedge, check request, advance model at posedge, check decode at next negedge.
    task automatic step(input bit st, input bit fl, input logic [31:0] rd, input bit g,
                        input int d, input bit stale);
        bit ereq, grant, resp, keep;
        ent_t e;
        stall_i = st; flush_i = fl; redirect_pc_i = rd; imem_gnt_i = g;
        resp = m_out && (rcnt == 1);
        imem_rvalid_i = stale || resp;
        imem_rdata_i  = resp ? mem(m_opc) : $urandom;
        #1;
        ereq = !m_out && (bq.size() == 0) && !fl;
        chk("req", 32'(imem_req_o), 32'(ereq));
        if (ereq) chk("addr", imem_addr_o, m_pc);
        if (imem_req_o && g) glog.push_back(imem_addr_o);
        @(posedge clk_i);
        grant = ereq && g;
        keep  = resp && !m_kill && !fl;
        if (fl) begin
            m_di = NOP; m_dv = 1'b0;
        end else if (!st) begin
            if (bq.size() != 0) begin
                e = bq.pop_front(); m_di = e.i; m_dpc = e.p; m_dv = 1'b1;
            end else if (keep) begin
                m_di = mem(m_opc); m_dpc = m_opc; m_dv = 1'b1;
            end else begin
                m_di = NOP; m_dv = 1'b0;
            end
        end
        if (fl) bq.delete();
        else if (st && keep) bq.push_back('{i: mem(m_opc), p: m_opc});
        if (resp) begin
            m_out = 1'b0; m_kill = 1'b0;
        end else if (m_out) begin
            rcnt--;
            if (fl) m_kill = 1'b1;
        end
        if (grant) begin
            m_out = 1'b1; m_kill = 1'b0; m_opc = m_pc; rcnt = d;
        end
        if (fl) m_pc = {rd[31:2], 2'b00};
        else if (grant) m_pc = m_pc + 32'd4;
        @(negedge clk_i);
        chk("dvalid", 32'(valid_decode_o), 32'(m_dv));
        chk("dinstr", instr_decode_o, m_di);
        if (m_dv) chk("dpc", pc_decode_o, m_dpc);
        if (valid_decode_o) dlog.push_back(pc_decode_o);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"},   32'(imem_req_o), 32'h0);
        chk({tag, "_valid"}, 32'(valid_decode_o), 32'h0);
        chk({tag, "_instr"}, instr_decode_o, NOP);
        chk({tag, "_pc"},    pc_decode_o, 32'h0);
    endtask

    initial begin
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        chk_reset_outs("rst");
        chk("rst_addr", imem_addr_o, 32'h0);
        rstn_i = 1'b1;

        // Back-to-back fetch 0,4,8 with one-cycle response; PC 8 arrives under a 3-cycle stall.
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        chk("stall_no_req", 32'(imem_req_o), 32'h0);
        step(1, 0, 0, 1, 1, 0);
        chk("stall_hold_pc", pc_decode_o, 32'h4);
        step(0, 0, 0, 1, 1, 0);
        chk("unstall_pc", pc_decode_o, 32'h8);
        chk("unstall_vld", 32'(valid_decode_o), 32'h1);
        chk("glog_n", 32'(glog.size()), 32'd3);
        chk("dlog_n", 32'(dlog.size()), 32'd3);
        if (glog.size() >= 3) begin
            chk("g0", glog[0], 32'h0); chk("g1", glog[1], 32'h4); chk("g2", glog[2], 32'h8);
        end
        if (dlog.size() >= 3) begin
            chk("d0", dlog[0], 32'h0); chk("d1", dlog[1], 32'h4); chk("d2", dlog[2], 32'h8);
        end

        // Flush to 0x100 while 0xC is in flight; its response must be dropped.
        step(0, 0, 0, 1, 3, 0);
        step(0, 1, 32'h100, 1, 1, 0);
        chk("flush_instr", instr_decode_o, NOP);
        chk("flush_vld", 32'(valid_decode_o), 32'h0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("redir_req", glog[$], 32'h100);
        step(0, 0, 0, 1, 1, 0);

        // Grant withheld for 4 cycles at 0x20.
        step(0, 1, 32'h20, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 1, 0);
            chk("gnt_lo_addr", imem_addr_o, 32'h20);
        end
        step(0, 0, 0, 1, 1, 0);

        // Response buffered under stall, then stall+flush together to 0x203.
        step(1, 0, 0, 1, 1, 0);
        step(1, 1, 32'h203, 1, 1, 0);
        step(0, 0, 0, 1, 2, 0);
        chk("sf_req", glog[$], 32'h200);
        chk("sf_buf_clr", 32'(valid_decode_o), 32'h0);
        step(0, 0, 0, 1, 1, 0);

        // Reset lands while waiting for 0x200; its late response must be ignored.
        rstn_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk_reset_outs("wrst");
        chk("wrst_addr", imem_addr_o, 32'h0);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        step(0, 0, 0, 1, 2, 1);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);

        for (int k = 0; k < 400; k++)
            step(($urandom % 4) == 0, ($urandom % 12) == 0, $urandom,
                 ($urandom % 3) != 0, int'($urandom_range(1, 3)), 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), used as the bubble instruction.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, all state on rising edge.
REQ-004 SHALL have port rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port stall_i, input, 1 bit: load-use stall from the hazard unit; hold decode register and PC.
REQ-006 SHALL have port flush_i, input, 1 bit: taken branch or jump from execute; kill younger instructions.
REQ-007 SHALL have port redirect_pc_i, input, 32 bits: target PC, sampled when flush_i=1.
REQ-008 SHALL have port imem_req_o, output, 1 bit: instruction-memory request.
REQ-009 SHALL have port imem_addr_o, output, 32 bits: request address, word aligned.
REQ-010 SHALL have port imem_gnt_i, input, 1 bit: request accepted when imem_req_o & imem_gnt_i.
REQ-011 SHALL have port imem_rvalid_i, input, 1 bit: response valid, one per granted request, 1 or more cycles after grant.
REQ-012 SHALL have port imem_rdata_i, input, 32 bits: response instruction.
REQ-013 SHALL have port instr_decode_o, output, 32 bits: instruction entering decode, feeding the hazard unit's fetch-side instruction input.
REQ-014 SHALL have port pc_decode_o, output, 32 bits: PC of instr_decode_o.
REQ-015 SHALL have port valid_decode_o, output, 1 bit: instr_decode_o is a real instruction, not a bubble.

Function
REQ-016 SHALL keep at most one outstanding (granted, unanswered) request.
REQ-017 SHALL implement FSM states RUN (no outstanding), WAIT (one outstanding, response kept) and DROP (one outstanding, response discarded).
REQ-018 SHALL assert imem_req_o only in RUN, with the holding buffer empty and flush_i=0; imem_addr_o = fetch PC.
REQ-019 SHALL hold imem_addr_o stable while imem_req_o=1 and imem_gnt_i=0; the request may be withdrawn only by flush_i.
REQ-020 SHALL, on grant, advance fetch PC by 4 (wrapping modulo 2^32) and move to WAIT; the granted PC is latched for the response.
REQ-021 SHALL, in WAIT on rvalid, return to RUN; a grant in the same cycle is not allowed, so the next request issues at the earliest the following cycle.
REQ-022 SHALL, on rvalid in WAIT with stall_i=0 and buffer empty, load instr_decode_o/pc_decode_o on that edge and set valid_decode_o=1.
REQ-023 SHALL, on rvalid in WAIT with stall_i=1, write the response into the 1-entry holding buffer and leave the decode register unchanged.
REQ-024 SHALL, with stall_i=0 and buffer full, load the decode register from the buffer and clear the buffer.
REQ-025 SHALL, with stall_i=0 and no new instruction available, load NOP_INSTR with valid_decode_o=0.
REQ-026 SHALL, on flush_i=1: set fetch PC to {redirect_pc_i[31:2],2'b00}, load the decode register with NOP_INSTR, valid 0, and clear the buffer.
REQ-027 SHALL, on flush_i=1, move WAIT to DROP; on flush with rvalid in the same cycle, discard that response and go to RUN.
REQ-028 SHALL, in DROP on rvalid, discard the data and go to RUN; a further flush in DROP only updates the PC.
REQ-029 SHALL give flush_i priority over stall_i when both are 1.
REQ-030 SHALL have fetch latency from grant to decode register of rvalid delay plus one edge; no combinational path from imem_rdata_i to outputs.

Reset
REQ-031 SHALL, on rstn_i=0, asynchronously set: fetch PC=RESET_PC, state=RUN, buffer empty, instr_decode_o=NOP_INSTR, pc_decode_o=0, valid_decode_o=0.
REQ-032 SHALL drive imem_req_o=0 during reset.
REQ-033 SHALL ignore any response arriving after reset for a request made before it.

Structure
REQ-034 SHALL place NOP_INSTR, the opcode constants and the fetch FSM state typedef in shared package rv32i_pkg.
REQ-035 SHALL implement the holding buffer as sub-module fetch_hold_buf (1 entry: instruction, PC, full flag).

Verification
REQ-036 SHALL test reset release with gnt=1 and rvalid one cycle later. Required: addresses 0,4,8 are requested, and decode shows PC 0,4,8 with valid=1 in that order.
REQ-037 SHALL test stall_i held for 3 cycles while the response for PC 8 arrives. Required: decode holds PC 4; PC 8 is buffered; no request issues; PC 8 appears on the first unstalled edge.
REQ-038 SHALL test flush_i with redirect 0x100 while PC 0xC is outstanding. Required: decode is NOP with valid=0; the 0xC response is dropped; the next request is 0x100.
REQ-039 SHALL test gnt held low for 4 cycles at address 0x20. Required: addr stays 0x20 and PC does not advance.
REQ-040 SHALL test stall_i=1 and flush_i=1 together with redirect 0x203. Required: flush wins, the next request is 0x200, and the buffer is cleared.
REQ-041 SHALL test rstn_i asserted while in WAIT. Required: all outputs take reset values at once, and the stale rvalid is ignored.
